// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data memory controller.
// Size encodings, FSM state type, wait-counter width and load extension.
package dmem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_RSVD = 2'b11
  } size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  localparam int WS_CNT_W = 4;

  function automatic logic [3:0] size_lanes(input size_e sz);
    case (sz)
      SZ_BYTE: return 4'b0001;
      SZ_HALF: return 4'b0011;
      SZ_WORD: return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  // Offset of the last byte touched, relative to the access address
  function automatic logic [1:0] size_last(input size_e sz);
    case (sz)
      SZ_HALF: return 2'd1;
      SZ_WORD: return 2'd3;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [31:0] load_extend(input logic [31:0] raw, input size_e sz,
                                              input logic uns);
    case (sz)
      SZ_BYTE: return uns ? {24'd0, raw[7:0]}  : {{24{raw[7]}}, raw[7:0]};
      SZ_HALF: return uns ? {16'd0, raw[15:0]} : {{16{raw[15]}}, raw[15:0]};
      default: return raw;
    endcase
  endfunction

endpackage

// File: rtl/data_mem_ctrl_if.sv
// Request/response bus between a load/store client (master) and data_mem_ctrl (slave).
// Valid/ready on both the request and the response channel.
interface data_mem_ctrl_if;
  import dmem_pkg::*;

  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  size_e       req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );

endinterface

// File: rtl/dmem_byte_array.sv
// Byte-wide storage seen as four little-endian lanes starting at addr (wrapping).
// Write on clk with per-lane enables; read of the four bytes is combinational.
module dmem_byte_array #(
  parameter int DEPTH_BYTES = 32768,
  parameter int AW          = $clog2(DEPTH_BYTES)
) (
  input  logic          clk,
  input  logic [3:0]    wr_be,
  input  logic [AW-1:0] addr,
  input  logic [31:0]   wdata,
  output logic [31:0]   rdata
);

  logic [7:0] mem [DEPTH_BYTES];

  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (wr_be[k]) mem[addr + AW'(k)] <= wdata[8*k +: 8];
    end
  end

  for (genvar k = 0; k < 4; k++) begin : g_lane
    logic [AW-1:0] idx;
    assign idx = addr + AW'(k);
    assign rdata[8*k +: 8] = mem[idx];
  end

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store controller: response 1+WAIT_STATES cycles after accept, held until rsp_ready; no queueing.
// Define DATA_MEM_CTRL_ALIGN_CHECK_EN to reject misaligned half/word accesses instead of splitting them.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int DEPTH_BYTES = 32768,
  parameter int WAIT_STATES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  data_mem_ctrl_if.slave bus,
  output logic           busy
);

  localparam int AW = $clog2(DEPTH_BYTES);

  state_e                state_q, state_d;
  logic [WS_CNT_W-1:0]   cnt_q, cnt_d;
  logic                  we_q, we_d, uns_q, uns_d;
  size_e                 size_q, size_d;
  logic [31:0]           addr_q, addr_d, wdata_q, wdata_d;
  logic                  rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d, busy_q, busy_d;
  logic [31:0]           rsp_rdata_q, rsp_rdata_d;

  logic                  a_we, a_uns, a_oob, a_misalign, a_err, commit;
  size_e                 a_size;
  logic [31:0]           a_addr, a_wdata, mem_rdata;
  logic [32:0]           a_last;
  logic [3:0]            mem_be;

  // With zero wait states the commit edge is the accept edge, so use the live request
  always_comb begin
    if (state_q == ST_IDLE) begin
      a_we = bus.req_we;  a_size = bus.req_size;  a_uns = bus.req_unsigned;
      a_addr = bus.req_addr;  a_wdata = bus.req_wdata;
    end else begin
      a_we = we_q;  a_size = size_q;  a_uns = uns_q;
      a_addr = addr_q;  a_wdata = wdata_q;
    end
  end

  assign a_last = {1'b0, a_addr} + {31'd0, size_last(a_size)};
  assign a_oob  = a_last >= 33'(DEPTH_BYTES);
`ifdef DATA_MEM_CTRL_ALIGN_CHECK_EN
  assign a_misalign = ((a_size == SZ_HALF) && a_addr[0]) ||
                      ((a_size == SZ_WORD) && (a_addr[1:0] != 2'b00));
`else
  assign a_misalign = 1'b0;
`endif
  assign a_err  = (a_size == SZ_RSVD) || a_oob || a_misalign;
  assign mem_be = (commit && a_we && !a_err && rst_n) ? size_lanes(a_size) : 4'b0000;

  dmem_byte_array #(.DEPTH_BYTES(DEPTH_BYTES), .AW(AW)) u_array (
    .clk   (clk),
    .wr_be (mem_be),
    .addr  (a_addr[AW-1:0]),
    .wdata (a_wdata),
    .rdata (mem_rdata)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    size_d      = size_q;
    uns_d       = uns_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_err_d   = rsp_err_q;
    rsp_rdata_d = rsp_rdata_q;
    commit      = 1'b0;
    case (state_q)
      ST_IDLE: if (bus.req_valid) begin
        we_d    = bus.req_we;
        size_d  = bus.req_size;
        uns_d   = bus.req_unsigned;
        addr_d  = bus.req_addr;
        wdata_d = bus.req_wdata;
        if (WAIT_STATES == 0) begin
          state_d = ST_RESP;
          commit  = 1'b1;
        end else begin
          state_d = ST_WAIT;
          cnt_d   = WS_CNT_W'(WAIT_STATES - 1);
        end
      end
      ST_WAIT: if (cnt_q == '0) begin
        state_d = ST_RESP;
        commit  = 1'b1;
      end else begin
        cnt_d = cnt_q - 1'b1;
      end
      ST_RESP: if (bus.rsp_ready) begin
        state_d     = ST_IDLE;
        rsp_valid_d = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
    if (commit) begin
      rsp_valid_d = 1'b1;
      rsp_err_d   = a_err;
      rsp_rdata_d = (a_err || a_we) ? 32'd0 : load_extend(mem_rdata, a_size, a_uns);
    end
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      size_q      <= SZ_BYTE;
      uns_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_rdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      size_q      <= size_d;
      uns_q       <= uns_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_rdata_q <= rsp_rdata_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.req_ready = (state_q == ST_IDLE);
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Directed bench for data_mem_ctrl (WAIT_STATES=2, DEPTH_BYTES=32768): vector table plus corner sequences.
module tb_data_mem_ctrl;
  import dmem_pkg::*;

  typedef struct {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        err;
    logic [31:0] rdata;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy;
  int   n_total = 0;
  int   n_pass  = 0;
  vec_t tv[$];

  data_mem_ctrl_if bus();

  data_mem_ctrl #(.DEPTH_BYTES(32768), .WAIT_STATES(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", nm, act, exp);
  endtask

  function automatic vec_t mk(input logic we, input logic [1:0] size, input logic uns,
                              input logic [31:0] addr, input logic [31:0] wdata,
                              input logic err, input logic [31:0] rdata, input string name);
    vec_t v;
    v.we = we; v.size = size; v.uns = uns; v.addr = addr; v.wdata = wdata;
    v.err = err; v.rdata = rdata; v.name = name;
    return v;
  endfunction

  task automatic drive(input vec_t v);
    bus.req_we       = v.we;
    bus.req_size     = size_e'(v.size);
    bus.req_unsigned = v.uns;
    bus.req_addr     = v.addr;
    bus.req_wdata    = v.wdata;
    bus.req_valid    = 1'b1;
  endtask

  // One access with rsp_ready high; the accept cycle is cycle 0
  task automatic access(input vec_t v);
    int lat;
    bit seen;
    @(negedge clk);
    chk({v.name, " req_ready"}, 32'(bus.req_ready), 32'd1);
    drive(v);
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk({v.name, " busy"}, 32'(busy), 32'd1);
    lat = 1;
    seen = 0;
    while (!seen && lat < 20) begin
      if (bus.rsp_valid) seen = 1;
      else begin
        @(negedge clk);
        lat++;
      end
    end
    chk({v.name, " latency"}, 32'(lat), 32'd3);
    chk({v.name, " err"}, 32'(bus.rsp_err), 32'(v.err));
    chk({v.name, " rdata"}, bus.rsp_rdata, v.rdata);
  endtask

  initial begin
    int pulses;
    int wt;
    vec_t v;
    logic [31:0] exp_lw11;
    logic        exp_err11;
`ifdef DATA_MEM_CTRL_ALIGN_CHECK_EN
    exp_lw11 = 32'h0000_0000; exp_err11 = 1'b1;
`else
    exp_lw11 = 32'h99DE_ADBE; exp_err11 = 1'b0;
`endif
    tv.push_back(mk(1, 2'b10, 0, 32'h10,   32'hDEADBEEF, 0, 32'h0,        "sw 0x10"));
    tv.push_back(mk(0, 2'b00, 0, 32'h10,   32'h0,        0, 32'hFFFFFFEF, "lb 0x10"));
    tv.push_back(mk(0, 2'b00, 1, 32'h13,   32'h0,        0, 32'h000000DE, "lbu 0x13"));
    tv.push_back(mk(0, 2'b10, 0, 32'h10,   32'h0,        0, 32'hDEADBEEF, "lw 0x10"));
    tv.push_back(mk(1, 2'b10, 0, 32'h20,   32'h44332211, 0, 32'h0,        "sw 0x20"));
    tv.push_back(mk(1, 2'b01, 0, 32'h22,   32'hFFFF8001, 0, 32'h0,        "sh 0x22"));
    tv.push_back(mk(0, 2'b01, 0, 32'h22,   32'h0,        0, 32'hFFFF8001, "lh 0x22"));
    tv.push_back(mk(0, 2'b01, 1, 32'h22,   32'h0,        0, 32'h00008001, "lhu 0x22"));
    tv.push_back(mk(0, 2'b10, 0, 32'h20,   32'h0,        0, 32'h80012211, "lw 0x20 lanes"));
    tv.push_back(mk(1, 2'b00, 0, 32'h14,   32'hFFFFFF99, 0, 32'h0,        "sb 0x14"));
    tv.push_back(mk(0, 2'b00, 1, 32'h14,   32'h0,        0, 32'h00000099, "lbu 0x14"));
    tv.push_back(mk(0, 2'b10, 0, 32'h11,   32'h0,        exp_err11, exp_lw11, "lw 0x11"));
    tv.push_back(mk(1, 2'b01, 0, 32'h7FFE, 32'h0000CAFE, 0, 32'h0,        "sh 0x7FFE"));
    tv.push_back(mk(1, 2'b10, 0, 32'h7FFE, 32'h12345678, 1, 32'h0,        "sw 0x7FFE oob"));
    tv.push_back(mk(0, 2'b01, 1, 32'h7FFE, 32'h0,        0, 32'h0000CAFE, "lhu 0x7FFE"));
    tv.push_back(mk(0, 2'b01, 1, 32'h7FFF, 32'h0,        1, 32'h0,        "lhu 0x7FFF oob"));
    tv.push_back(mk(0, 2'b00, 1, 32'h8000, 32'h0,        1, 32'h0,        "lbu 0x8000 oob"));
    tv.push_back(mk(0, 2'b00, 0, 32'hFFFFFFFF, 32'h0,    1, 32'h0,        "lb top oob"));
    tv.push_back(mk(1, 2'b10, 0, 32'h50,   32'h55667788, 0, 32'h0,        "sw 0x50"));
    tv.push_back(mk(1, 2'b11, 0, 32'h50,   32'h11223344, 1, 32'h0,        "st rsvd"));
    tv.push_back(mk(0, 2'b10, 0, 32'h50,   32'h0,        0, 32'h55667788, "lw 0x50"));
    tv.push_back(mk(0, 2'b11, 0, 32'h50,   32'h0,        1, 32'h0,        "ld rsvd"));
    tv.push_back(mk(1, 2'b10, 0, 32'h40,   32'h11111111, 0, 32'h0,        "sw 0x40"));
    tv.push_back(mk(0, 2'b10, 0, 32'h40,   32'h0,        0, 32'h11111111, "lw 0x40"));

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = SZ_BYTE;
    bus.req_unsigned = 1'b0; bus.req_addr = '0; bus.req_wdata = '0; bus.rsp_ready = 1'b1;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("reset req_ready", 32'(bus.req_ready), 32'd1);
    chk("reset rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("reset rsp_err",   32'(bus.rsp_err),   32'd0);
    chk("reset rsp_rdata", bus.rsp_rdata,      32'd0);
    chk("reset busy",      32'(busy),          32'd0);

    foreach (tv[i]) access(tv[i]);

    // Backpressure: response must hold, new requests must be ignored
    @(negedge clk);
    bus.rsp_ready = 1'b0;
    drive(mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h0, "bp lw"));
    @(negedge clk);
    bus.req_valid = 1'b0;
    wt = 0;
    while (!bus.rsp_valid && wt < 20) begin
      @(negedge clk);
      wt++;
    end
    chk("bp wait", 32'(wt), 32'd2);
    drive(mk(1, 2'b10, 0, 32'h10, 32'h0, 0, 32'h0, "bp intruder"));
    for (int i = 0; i < 5; i++) begin
      chk($sformatf("bp rsp_valid c%0d", i), 32'(bus.rsp_valid), 32'd1);
      chk($sformatf("bp rdata c%0d", i), bus.rsp_rdata, 32'hDEADBEEF);
      chk($sformatf("bp req_ready c%0d", i), 32'(bus.req_ready), 32'd0);
      @(negedge clk);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk("bp release rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("bp release req_ready", 32'(bus.req_ready), 32'd1);
    access(mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'hDEADBEEF, "lw 0x10 after bp"));

    // Throughput with req_valid held: one response every WAIT_STATES+2 cycles
    @(negedge clk);
    drive(mk(0, 2'b10, 0, 32'h10, 32'h0, 0, 32'h0, "tp lw"));
    pulses = 0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus.rsp_valid) pulses++;
    end
    bus.req_valid = 1'b0;
    chk("throughput pulses", 32'(pulses), 32'd3);
    @(negedge clk);
    chk("throughput idle busy", 32'(busy), 32'd0);

    // Reset during WAIT drops the store
    drive(mk(1, 2'b10, 0, 32'h40, 32'hAAAAAAAA, 0, 32'h0, "rst sw"));
    @(negedge clk);
    bus.req_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst req_ready", 32'(bus.req_ready), 32'd1);
    chk("rst busy",      32'(busy),          32'd0);
    access(mk(0, 2'b10, 0, 32'h40, 32'h0, 0, 32'h11111111, "lw 0x40 after rst"));

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1);
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 SHALL have parameter DEPTH_BYTES, default 32768, byte capacity; power of two, at least 4.
REQ-002 SHALL have parameter WAIT_STATES, default 2, extra access cycles; legal range 0..15.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, synchronous and active-low.
REQ-005 SHALL have port req_valid, input, 1 bit: request present.
REQ-006 SHALL have port req_ready, output, 1 bit: request accepted this cycle when high together with req_valid.
REQ-007 SHALL have port req_we, input, 1 bit: 1 = store, 0 = load.
REQ-008 SHALL have port req_size, input, 2 bits: 00 byte, 01 half, 10 word, 11 reserved.
REQ-009 SHALL have port req_unsigned, input, 1 bit: load zero-extends when 1 and sign-extends when 0.
REQ-010 SHALL have port req_addr, input, 32 bits: byte address.
REQ-011 SHALL have port req_wdata, input, 32 bits: store data, LSB-aligned.
REQ-012 SHALL have port rsp_valid, output, 1 bit: response present.
REQ-013 SHALL have port rsp_ready, input, 1 bit: consumer takes the response.
REQ-014 SHALL have port rsp_rdata, output, 32 bits: extended load data; 0 for stores and errors.
REQ-015 SHALL have port rsp_err, output, 1 bit: access rejected.
REQ-016 SHALL have port busy, output, 1 bit: FSM not in IDLE.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT and RESP.
- IDLE to WAIT on accept when WAIT_STATES>0.
- IDLE to RESP on accept when WAIT_STATES=0.
- WAIT to RESP after WAIT_STATES cycles, counted by a down-counter.
- RESP to IDLE on rsp_valid && rsp_ready.
REQ-018 SHALL drive req_ready=1 only in IDLE; request fields SHALL be captured into registers on accept.
REQ-019 SHALL assert rsp_valid exactly 1+WAIT_STATES cycles after the accept edge.
REQ-020 SHALL commit a store to the array, and sample load data, on the edge entering RESP; only the enabled bytes change.
REQ-021 SHALL store little-endian: byte k of the data at addr+k.
REQ-022 SHALL extend loads from bit 7 (byte) or bit 15 (half) according to the captured req_unsigned; a word load returns 32 bits unchanged.
REQ-023 SHALL hold rsp_rdata and rsp_err stable while rsp_valid=1 and rsp_ready=0.
REQ-024 SHALL flag rsp_err=1 with no write and rsp_rdata=0 when:
- req_size=11, or
- the last byte accessed is at or beyond DEPTH_BYTES.
REQ-025 SHALL ignore req_valid outside IDLE; no request queueing.
REQ-026 SHALL give a throughput of one access per WAIT_STATES+2 cycles with rsp_ready held high.

Reset
REQ-027 SHALL, on rising clk with rst_n=0:
- go to IDLE;
- clear the wait counter;
- set rsp_valid=0, rsp_err=0, rsp_rdata=0 and busy=0, so req_ready=1 afterwards.
REQ-028 SHALL drop an uncommitted store when reset occurs in WAIT; array contents SHALL NOT be cleared by reset.

Configuration
REQ-029 SHALL support macro DATA_MEM_CTRL_ALIGN_CHECK_EN.
- Defined: a half access with addr[0]=1, or a word access with addr[1:0]!=00, returns rsp_err=1, performs no write, and returns rsp_rdata=0.
- Undefined: unaligned accesses are performed byte-wise at addr..addr+n-1, subject to REQ-024.

Structure
REQ-030 SHALL take from shared package dmem_pkg:
- the size encodings;
- the FSM state type;
- the WAIT_STATES counter width constant.
REQ-031 SHALL instantiate sub-module dmem_byte_array: DEPTH_BYTES x 8 storage, four byte lanes, synchronous write with per-lane enables, combinational read of four consecutive bytes.

Verification (WAIT_STATES=2, DEPTH_BYTES=32768)
REQ-032 SHALL cover: sw 0xDEADBEEF at 0x10, then lb 0x10, then lbu 0x13 -> 0xFFFFFFEF and 0x000000DE; each rsp_valid appears 3 cycles after accept.
REQ-033 SHALL cover: sh 0x8001 at 0x22, then lh 0x22, then lhu 0x22 -> 0xFFFF8001 and 0x00008001.
REQ-034 SHALL cover: rsp_ready=0 held for 5 cycles -> rsp_valid and rsp_rdata stable and req_ready=0 throughout; transfer completes on the first cycle rsp_ready=1.
REQ-035 SHALL cover: lw at 0x11.
- Macro defined -> rsp_err=1 and rsp_rdata=0.
- Macro undefined -> bytes 0x14..0x11 returned with rsp_err=0.
REQ-036 SHALL cover: sw 0x12345678 at 0x7FFE -> rsp_err=1, and a later lhu 0x7FFE returns the prior contents.
REQ-037 SHALL cover: rst_n=0 for one cycle during WAIT of sw 0xAAAAAAAA at 0x40 -> rsp_valid=0 and req_ready=1 next cycle; lw 0x40 returns the prior contents.
